// File: rtl/leg_shift_pkg.sv
// Shared shift-type and RSR sequencing types for the Execute-stage operand shifter.
package leg_shift_pkg;

  typedef enum logic [1:0] {
    LSL = 2'b00,
    LSR = 2'b01,
    ASR = 2'b10,
    ROR = 2'b11
  } shift_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RSR  = 1'b1
  } rsr_state_t;

endpackage

// File: rtl/rsr_shifter_if.sv
// Execute-stage shifter bus: control/operand inputs and ALU-facing results.
interface rsr_shifter_if;
  import leg_shift_pkg::*;

  logic        validE;
  logic        stallE;
  logic        flushE;
  logic        RselectE;
  shift_t      shiftTypeE;
  logic [4:0]  shamt5E;
  logic [31:0] operandE;
  logic        prevCflag;
  logic [31:0] shiftedE;
  logic        shifterCarryOut_cycle1E;
  logic        shifterCarryOut_cycle2E;
  logic        prevRSRstateE;
  logic        portSelRsE;
  logic        rsrStallE;

  modport master (
    output validE, stallE, flushE, RselectE, shiftTypeE, shamt5E, operandE, prevCflag,
    input  shiftedE, shifterCarryOut_cycle1E, shifterCarryOut_cycle2E, prevRSRstateE,
           portSelRsE, rsrStallE
  );

  modport slave (
    input  validE, stallE, flushE, RselectE, shiftTypeE, shamt5E, operandE, prevCflag,
    output shiftedE, shifterCarryOut_cycle1E, shifterCarryOut_cycle2E, prevRSRstateE,
           portSelRsE, rsrStallE
  );

endinterface

// File: rtl/shift_core.sv
// Combinational 32-bit barrel shifter with carry-out; imm selects the #0 encodings
// (LSR/ASR #32, RRX) used by immediate-amount shifts.
module shift_core
  import leg_shift_pkg::*;
(
  input  logic [31:0] value,
  input  logic [7:0]  amount,
  input  shift_t      stype,
  input  logic        c_in,
  input  logic        imm,
  output logic [31:0] result,
  output logic        carry
);

  logic        amt_zero;
  logic        amt_big;
  logic [5:0]  n;
  logic [5:0]  rot_n;
  logic [32:0] lsl_w;
  logic [32:0] lsr_w;
  logic [32:0] asr_w;
  logic [31:0] rot_w;

  assign amt_zero = (amount == 8'd0);
  assign amt_big  = (amount > 8'd32);
  // Amounts >= 32 saturate to 32; imm #0 also means 32 for the right shifts.
  assign n        = (amt_zero && imm) || (amount >= 8'd32) ? 6'd32 : {1'b0, amount[4:0]};
  assign rot_n    = {1'b0, amount[4:0]};

  // One guard bit beside the value captures the last bit shifted out.
  assign lsl_w = {1'b0, value} << n;
  assign lsr_w = {value, 1'b0} >> n;
  assign asr_w = $signed({value, 1'b0}) >>> n;
  assign rot_w = (value >> rot_n) | (value << (6'd32 - rot_n));

  always_comb begin
    result = value;
    carry  = c_in;
    unique case (stype)
      LSL: begin
        if (!amt_zero) begin
          result = lsl_w[31:0];
          carry  = amt_big ? 1'b0 : lsl_w[32];
        end
      end
      LSR: begin
        if (!amt_zero || imm) begin
          result = lsr_w[32:1];
          carry  = amt_big ? 1'b0 : lsr_w[0];
        end
      end
      ASR: begin
        if (!amt_zero || imm) begin
          result = asr_w[32:1];
          carry  = asr_w[0];
        end
      end
      ROR: begin
        if (amt_zero && imm) begin
          result = {c_in, value[31:1]};
          carry  = value[0];
        end else if (!amt_zero) begin
          result = rot_w;
          carry  = rot_w[31];
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rsr_shifter.sv
// Execute-stage B-operand shifter: same-cycle immediate shifts and a two-cycle
// register-shifted-register sequence over the shared third read port.
module rsr_shifter
  import leg_shift_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  rsr_shifter_if.slave bus
);

  rsr_state_t state_q, state_d;
  logic [7:0] amt_q, amt_d;
  shift_t     type_q, type_d;

  logic [31:0] imm_result, rsr_result;
  logic        imm_carry, rsr_carry;
  logic        rsr_start;

  assign rsr_start = bus.validE & bus.RselectE & ~bus.stallE & ~bus.flushE;

  always_comb begin
    state_d = state_q;
    amt_d   = amt_q;
    type_d  = type_q;
    unique case (state_q)
      S_IDLE: begin
        if (rsr_start) begin
          state_d = S_RSR;
          amt_d   = bus.operandE[7:0];
          type_d  = bus.shiftTypeE;
        end
      end
      S_RSR: begin
        if (!bus.stallE) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (bus.flushE) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      amt_q   <= 8'd0;
      type_q  <= LSL;
    end else begin
      state_q <= state_d;
      amt_q   <= amt_d;
      type_q  <= type_d;
    end
  end

  shift_core u_imm_shift (
    .value  (bus.operandE),
    .amount ({3'b000, bus.shamt5E}),
    .stype  (bus.shiftTypeE),
    .c_in   (bus.prevCflag),
    .imm    (1'b1),
    .result (imm_result),
    .carry  (imm_carry)
  );

  shift_core u_rsr_shift (
    .value  (bus.operandE),
    .amount (amt_q),
    .stype  (type_q),
    .c_in   (bus.prevCflag),
    .imm    (1'b0),
    .result (rsr_result),
    .carry  (rsr_carry)
  );

  always_comb begin
    bus.prevRSRstateE           = (state_q == S_RSR);
    bus.portSelRsE              = (state_q == S_IDLE) & bus.validE & bus.RselectE;
    bus.rsrStallE               = bus.portSelRsE;
    bus.shiftedE                = (state_q == S_RSR) ? rsr_result : imm_result;
    bus.shifterCarryOut_cycle1E = imm_carry;
    bus.shifterCarryOut_cycle2E = rsr_carry;
  end

endmodule
